// File: rtl/separable_switch_allocator_pkg.sv
// Shared NoC parameters and the port direction type used by the switch allocator.
package noc_params;

    localparam int VC_NUM       = 2;
    localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_NUM_DEF = 5;
    localparam int PORT_SIZE    = $clog2(PORT_NUM_DEF);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/separable_switch_allocator_if.sv
// Request/grant bundle between the router input stage and the switch allocator.
interface separable_switch_allocator_if
    import noc_params::*;
#(
    parameter int PORT_NUM = 5
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]               switch_request_i;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]               out_port_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]               on_off_i;

    logic  [PORT_NUM-1:0]                           valid_sel_o;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]              vc_sel_o;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]            input_vc_sel_o;
    logic  [PORT_NUM-1:0]                           valid_flit_o;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]              downstream_vc_o;

    modport master (
        output switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        input  valid_sel_o, vc_sel_o, input_vc_sel_o, valid_flit_o, downstream_vc_o
    );

    modport slave (
        input  switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        output valid_sel_o, vc_sel_o, input_vc_sel_o, valid_flit_o, downstream_vc_o
    );

endinterface

// File: rtl/separable_switch_allocator_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer; the pointer
// moves past the winner only when the caller confirms the grant via update_i.
module round_robin_arbiter #(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] request_i,
    input  logic                  update_i,
    output logic [AGENTS_NUM-1:0] grant_o
);

    localparam int               PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(AGENTS_NUM - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        idx       = 0;
        grant_o   = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < AGENTS_NUM; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= AGENTS_NUM) idx = idx - AGENTS_NUM;
            if (!found && request_i[idx[PTR_W-1:0]]) begin
                found                   = 1'b1;
                grant_o[idx[PTR_W-1:0]] = 1'b1;
                grant_idx               = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && found) begin
            ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/separable_switch_allocator.sv
// Two-stage separable switch allocator: per-input VC round-robin, then per-output
// input round-robin; fully combinational grant, only arbiter pointers are state.
module separable_switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = 5
) (
    input logic                         clk,
    input logic                         rst,
    separable_switch_allocator_if.slave bus
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]     eligible;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]     vc_grant;
    logic  [PORT_NUM-1:0]                 s1_valid;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]    s1_vc;
    port_t [PORT_NUM-1:0]                 s1_port;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]   out_req;     // [output][input]
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]   port_grant;  // [output][input]

    logic  [PORT_NUM-1:0]                 valid_sel;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]    vc_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]  input_vc_sel;
    logic  [PORT_NUM-1:0]                 valid_flit;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]    dvc_out;

    // A request only competes if the downstream VC it targets can take a flit now.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (int'(bus.out_port_i[p][v]) < PORT_NUM) begin
                    eligible[p][v] = bus.switch_request_i[p][v] &&
                                     bus.on_off_i[bus.out_port_i[p][v]][bus.downstream_vc_i[p][v]];
                end
            end
        end
    end

    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_in_arb
        round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (eligible[gp]),
            .update_i  (valid_sel[gp]),
            .grant_o   (vc_grant[gp])
        );
    end

    always_comb begin
        s1_valid = '0;
        s1_vc    = '0;
        out_req  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            s1_port[p]  = LOCAL;
            s1_valid[p] = |vc_grant[p];
            for (int v = 0; v < VC_NUM; v++) begin
                if (vc_grant[p][v]) begin
                    s1_vc[p]   = VC_SIZE'(v);
                    s1_port[p] = bus.out_port_i[p][v];
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                out_req[o][p] = s1_valid[p] && (int'(s1_port[p]) == o);
            end
        end
    end

    // An output with any stage-2 request always grants, so its pointer advances then.
    for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
        round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (out_req[go]),
            .update_i  (|out_req[go]),
            .grant_o   (port_grant[go])
        );
    end

    always_comb begin
        valid_sel    = '0;
        vc_sel       = '0;
        input_vc_sel = '0;
        valid_flit   = '0;
        dvc_out      = '0;
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (port_grant[o][p]) begin
                        valid_flit[o]   = 1'b1;
                        input_vc_sel[o] = PORT_SIZE'(p);
                        dvc_out[o]      = bus.downstream_vc_i[p][s1_vc[p]];
                        valid_sel[p]    = 1'b1;
                        vc_sel[p]       = s1_vc[p];
                    end
                end
            end
        end
    end

    assign bus.valid_sel_o     = valid_sel;
    assign bus.vc_sel_o        = vc_sel;
    assign bus.input_vc_sel_o  = input_vc_sel;
    assign bus.valid_flit_o    = valid_flit;
    assign bus.downstream_vc_o = dvc_out;

endmodule

// File: tb/tb_separable_switch_allocator.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural allocator model.
module tb_separable_switch_allocator;
    import noc_params::*;

    localparam int PN       = 5;
    localparam int VN       = VC_NUM;
    localparam int MAX_WAIT = PN * VN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    separable_switch_allocator_if #(.PORT_NUM(PN)) bus ();

    separable_switch_allocator #(.PORT_NUM(PN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: round-robin pointers as plain integers.
    int m_in_ptr [PN];
    int m_out_ptr[PN];
    int win      [PN];
    logic [PN-1:0]                e_valid_sel, e_valid_flit;
    logic [PN-1:0][VC_SIZE-1:0]   e_vc_sel, e_dvc;
    logic [PN-1:0][PORT_SIZE-1:0] e_ivs;
    bit   granted_last[PN][VN];
    bit   starve_en = 1'b0;
    int   wait_cnt[PN][VN];
    int   max_wait = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit elig(int p, int v);
        int op;
        op = int'(bus.out_port_i[p][v]);
        if (!bus.switch_request_i[p][v] || op >= PN) return 1'b0;
        return bus.on_off_i[op][bus.downstream_vc_i[p][v]];
    endfunction

    // Compare process: outputs are stable mid-cycle, pointers move at the next rising edge.
    always @(negedge clk) begin
        int  v;
        int  p;
        bit  done;
        e_valid_sel  = '0;
        e_valid_flit = '0;
        e_vc_sel     = '0;
        e_dvc        = '0;
        e_ivs        = '0;
        for (int i = 0; i < PN; i++) win[i] = -1;
        if (!rst) begin
            for (int i = 0; i < PN; i++) begin
                for (int k = 0; k < VN; k++) begin
                    v = (m_in_ptr[i] + k) % VN;
                    if (win[i] < 0 && elig(i, v)) win[i] = v;
                end
            end
            for (int o = 0; o < PN; o++) begin
                done = 1'b0;
                for (int k = 0; k < PN; k++) begin
                    p = (m_out_ptr[o] + k) % PN;
                    if (!done && win[p] >= 0 && int'(bus.out_port_i[p][win[p]]) == o) begin
                        done            = 1'b1;
                        e_valid_flit[o] = 1'b1;
                        e_ivs[o]        = PORT_SIZE'(p);
                        e_dvc[o]        = bus.downstream_vc_i[p][win[p]];
                        e_valid_sel[p]  = 1'b1;
                        e_vc_sel[p]     = VC_SIZE'(win[p]);
                    end
                end
            end
        end
        check("valid_sel",     64'(bus.valid_sel_o),     64'(e_valid_sel));
        check("vc_sel",        64'(bus.vc_sel_o),        64'(e_vc_sel));
        check("input_vc_sel",  64'(bus.input_vc_sel_o),  64'(e_ivs));
        check("valid_flit",    64'(bus.valid_flit_o),    64'(e_valid_flit));
        check("downstream_vc", 64'(bus.downstream_vc_o), 64'(e_dvc));
        for (int i = 0; i < PN; i++) begin
            if (bus.valid_sel_o[i]) check("grant_eligible", 64'(elig(i, int'(bus.vc_sel_o[i]))), 64'd1);
        end

        if (starve_en) begin
            for (int i = 0; i < PN; i++) begin
                for (int j = 0; j < VN; j++) begin
                    if (elig(i, j) && !(bus.valid_sel_o[i] && int'(bus.vc_sel_o[i]) == j)) wait_cnt[i][j]++;
                    else wait_cnt[i][j] = 0;
                    if (wait_cnt[i][j] > max_wait) max_wait = wait_cnt[i][j];
                end
            end
        end

        for (int i = 0; i < PN; i++) begin
            if (rst) begin
                m_in_ptr[i]  = 0;
                m_out_ptr[i] = 0;
            end else begin
                if (e_valid_sel[i])  m_in_ptr[i]  = (win[i] + 1) % VN;
                if (e_valid_flit[i]) m_out_ptr[i] = (int'(e_ivs[i]) + 1) % PN;
            end
            for (int j = 0; j < VN; j++) granted_last[i][j] = e_valid_sel[i] && (int'(e_vc_sel[i]) == j);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.switch_request_i = '0;
        bus.downstream_vc_i  = '0;
        bus.on_off_i         = '1;
        for (int p = 0; p < PN; p++)
            for (int v = 0; v < VN; v++) bus.out_port_i[p][v] = LOCAL;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic new_request(input int p, input int v);
        bus.switch_request_i[p][v] = 1'b1;
        bus.out_port_i[p][v]       = port_t'($urandom_range(0, PN - 1));
        bus.downstream_vc_i[p][v]  = VC_SIZE'($urandom_range(0, VN - 1));
    endtask

    initial begin
        int exp_cont[4];
        exp_cont = '{1, 2, 3, 1};

        // Reset forces every output low even with all requests up.
        rst = 1'b1;
        clear_inputs();
        bus.switch_request_i = '1;
        #1;
        check("rst_valid_sel",     64'(bus.valid_sel_o),     64'd0);
        check("rst_valid_flit",    64'(bus.valid_flit_o),    64'd0);
        check("rst_vc_sel",        64'(bus.vc_sel_o),        64'd0);
        check("rst_input_vc_sel",  64'(bus.input_vc_sel_o),  64'd0);
        check("rst_downstream_vc", 64'(bus.downstream_vc_o), 64'd0);
        tick();

        // First cycle out of reset, single requester granted every cycle.
        rst = 1'b0;
        clear_inputs();
        bus.switch_request_i[0][0] = 1'b1;
        bus.out_port_i[0][0]       = EAST;
        #1;
        check("first_vc_sel",       64'(bus.vc_sel_o[0]),           64'd0);
        check("first_input_vc_sel", 64'(bus.input_vc_sel_o[EAST]),  64'd0);
        check("first_valid_flit",   64'(bus.valid_flit_o),          64'b10000);
        for (int i = 0; i < 3; i++) begin
            check("single_valid_sel", 64'(bus.valid_sel_o), 64'b00001);
            tick();
        end

        // Output contention on LOCAL from inputs 1..3.
        do_reset();
        for (int p = 1; p <= 3; p++) bus.switch_request_i[p][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("contention_winner", 64'(bus.input_vc_sel_o[LOCAL]), 64'(exp_cont[i]));
            tick();
        end

        // VC fairness at input 2.
        do_reset();
        bus.switch_request_i[2] = 2'b11;
        bus.out_port_i[2][0]    = NORTH;
        bus.out_port_i[2][1]    = SOUTH;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("vc_fair_sel",   64'(bus.vc_sel_o[2]),    64'(i % 2));
            check("vc_fair_valid", 64'(bus.valid_sel_o[2]), 64'd1);
            tick();
        end

        // Flow control masks the request; pointers must not move while masked.
        do_reset();
        bus.on_off_i[NORTH][1]     = 1'b0;
        bus.switch_request_i[0][1] = 1'b1;
        bus.out_port_i[0][1]       = NORTH;
        bus.downstream_vc_i[0][1]  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("masked_valid_sel",  64'(bus.valid_sel_o),  64'd0);
            check("masked_valid_flit", 64'(bus.valid_flit_o), 64'd0);
            tick();
        end
        bus.on_off_i[NORTH][1]     = 1'b1;
        bus.switch_request_i[3][0] = 1'b1;
        bus.out_port_i[3][0]       = NORTH;
        #1;
        check("unmask_valid_sel", 64'(bus.valid_sel_o),            64'b00001);
        check("unmask_vc_sel",    64'(bus.vc_sel_o[0]),            64'd1);
        check("unmask_ivs",       64'(bus.input_vc_sel_o[NORTH]),  64'd0);
        check("unmask_dvc",       64'(bus.downstream_vc_o[NORTH]), 64'd1);
        tick();

        // Stage-2 loss keeps the loser's VC pointer.
        do_reset();
        bus.switch_request_i[0][0] = 1'b1;
        bus.out_port_i[0][0]       = EAST;
        bus.switch_request_i[1]    = 2'b11;
        bus.out_port_i[1][0]       = EAST;
        bus.out_port_i[1][1]       = WEST;
        #1;
        check("loss_valid_sel", 64'(bus.valid_sel_o),           64'b00001);
        check("loss_ivs",       64'(bus.input_vc_sel_o[EAST]),  64'd0);
        tick();
        bus.switch_request_i[0][0] = 1'b0;
        #1;
        check("reoffer_valid_sel", 64'(bus.valid_sel_o),          64'b00010);
        check("reoffer_vc_sel",    64'(bus.vc_sel_o[1]),          64'd0);
        check("reoffer_ivs",       64'(bus.input_vc_sel_o[EAST]), 64'd1);
        tick();

        // Fully random traffic with occasional mid-run resets.
        for (int c = 0; c < 5000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < PN; p++) begin
                for (int v = 0; v < VN; v++) begin
                    bus.switch_request_i[p][v] = ($urandom_range(0, 2) != 0);
                    bus.out_port_i[p][v]       = port_t'($urandom_range(0, PN - 1));
                    bus.downstream_vc_i[p][v]  = VC_SIZE'($urandom_range(0, VN - 1));
                    bus.on_off_i[p][v]         = ($urandom_range(0, 3) != 0);
                end
            end
            tick();
        end

        // Persistent requests with open flow control: bounded waiting for every VC.
        rst = 1'b0;
        clear_inputs();
        starve_en = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            for (int p = 0; p < PN; p++) begin
                for (int v = 0; v < VN; v++) begin
                    if (!bus.switch_request_i[p][v] || granted_last[p][v]) begin
                        bus.switch_request_i[p][v] = 1'b0;
                        if ($urandom_range(0, 9) < 7) new_request(p, v);
                    end
                end
            end
            tick();
        end
        starve_en = 1'b0;
        check("starvation_bound", 64'(max_wait < MAX_WAIT), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
